imem_loader: RTL and testbench

Boot-side counterpart of the CPU bench harness. It receives a program as a byte stream, zero-fills and then writes the instruction memory, and releases the CPU by driving `start_o`. While the CPU runs, it counts run cycles, stalls and flushes, and it halts the CPU after a fixed cycle budget. It sits between an external byte source (UART or host FIFO) and the `CPU` top's instruction-memory write port and `start_i`.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_sat_counter.sv | 31 +++
 rtl/imem_loader.sv | 206 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    HDR_LO,
    HDR_HI,
    LOAD,
    SETTLE,
    RUN,
    DONE,
    ERR
  } state_e;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: zero-fills instruction memory, loads a byte-stream program,
// then runs the CPU for a fixed cycle budget while counting stalls and flushes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int MAX_CYCLES = 64,
  parameter int CW         = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_data_o,
  output logic          start_o,
  input  logic          stall_i,
  input  logic          branch_i,
  input  logic          flush_i,
  output logic [CW-1:0] run_cycles_o,
  output logic [CW-1:0] stall_cnt_o,
  output logic [CW-1:0] flush_cnt_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int NW = HDR_BYTES * 8;

  state_e        state_q, state_d;
  logic [AW:0]   clr_q, clr_d;
  logic [7:0]    hdr_lo_q, hdr_lo_d;
  logic [NW-1:0] count_q, count_d;
  logic [1:0]    lane_q, lane_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [23:0]   buf_q, buf_d;

  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          run_en;
  logic          clr_done;
  logic          last_word;
  logic          last_run;
  logic [NW-1:0] hdr_n;

  assign accept    = valid_i && ready_q;
  assign hdr_n     = {data_i, hdr_lo_q};
  assign run_en    = (state_q == RUN);
  assign clr_done  = (clr_q == (AW+1)'(DEPTH));
  assign last_word = (lane_q == 2'd3) && (NW'(widx_q) == (count_q - NW'(1)));
  assign last_run  = run_en && (run_cycles_o == CW'(MAX_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_done) state_d = HDR_LO;
      HDR_LO:  if (accept) state_d = HDR_HI;
      HDR_HI: begin
        if (accept) begin
          if (hdr_n > NW'(DEPTH)) begin
            state_d = ERR;
          end else if (hdr_n == '0) begin
            state_d = SETTLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD:    if (accept && last_word) state_d = SETTLE;
      SETTLE:  state_d = RUN;
      RUN:     if (last_run) state_d = DONE;
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = CLEAR;
    endcase
  end

  // start/done follow the registered state, so start rises one cycle after
  // RUN is entered and stays high for exactly the RUN duration.
  always_comb begin
    clr_d    = clr_q;
    hdr_lo_d = hdr_lo_q;
    count_d  = count_q;
    lane_d   = lane_q;
    widx_d   = widx_q;
    buf_d    = buf_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    ready_d  = (state_d == HDR_LO) || (state_d == HDR_HI) || (state_d == LOAD);
    start_d  = run_en;
    done_d   = (state_q == DONE);
    err_d    = (state_d == ERR);
    case (state_q)
      CLEAR: begin
        if (!clr_done) begin
          we_d   = 1'b1;
          addr_d = clr_q[AW-1:0];
          data_d = '0;
          clr_d  = clr_q + (AW+1)'(1);
        end
      end
      HDR_LO: if (accept) hdr_lo_d = data_i;
      HDR_HI: if (accept) count_d = hdr_n;
      LOAD: begin
        if (accept) begin
          if (lane_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = widx_q;
            data_d = {data_i, buf_q};
            widx_d = widx_q + AW'(1);
            lane_d = 2'd0;
          end else begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
              2'd0:    buf_d[7:0]   = data_i;
              2'd1:    buf_d[15:8]  = data_i;
              default: buf_d[23:16] = data_i;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_q    <= '0;
      hdr_lo_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      widx_q   <= '0;
      buf_q    <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clr_q    <= clr_d;
      hdr_lo_q <= hdr_lo_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      widx_q   <= widx_d;
      buf_q    <= buf_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(.CW(CW)) u_run_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (run_en),
    .cnt_o (run_cycles_o)
  );

  // A stall coinciding with a branch is the branch's own bubble, not a hazard.
  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (run_en && stall_i && !branch_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (run_en && flush_i),
    .cnt_o (flush_cnt_o)
  );

  assign ready_o     = ready_q;
  assign imem_we_o   = we_q;
  assign imem_addr_o = addr_q;
  assign imem_data_o = data_q;
  assign start_o     = start_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: zero-fill, program load, run budget,
// counters, header error and mid-word reset, checked against a stream model.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int MAXC  = 64;
  localparam int CW    = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    dataIn = 8'h00;
  logic          validIn = 1'b0;
  logic          stallIn = 1'b0;
  logic          branchIn = 1'b0;
  logic          flushIn = 1'b0;
  logic          readyOut;
  logic          imemWe;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemData;
  logic          startOut;
  logic [CW-1:0] runCycles;
  logic [CW-1:0] stallCnt;
  logic [CW-1:0] flushCnt;
  logic          doneOut;
  logic          errOut;

  always #5 clock = ~clock;

  imem_loader #(
    .DEPTH(DEPTH), .AW(AW), .MAX_CYCLES(MAXC), .CW(CW)
  ) dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .data_i       (dataIn),
    .valid_i      (validIn),
    .ready_o      (readyOut),
    .imem_we_o    (imemWe),
    .imem_addr_o  (imemAddr),
    .imem_data_o  (imemData),
    .start_o      (startOut),
    .stall_i      (stallIn),
    .branch_i     (branchIn),
    .flush_i      (flushIn),
    .run_cycles_o (runCycles),
    .stall_cnt_o  (stallCnt),
    .flush_cnt_o  (flushCnt),
    .done_o       (doneOut),
    .err_o        (errOut)
  );

  int          total = 0;
  int          bad = 0;
  int          cycleNo = 0;
  int          releaseCyc = 0;
  int          startRise, startFall, startHigh, doneRise, firstReady;
  logic        prevStart = 1'b0;
  logic        prevDone = 1'b0;
  int          wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  logic [31:0] prog[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    startRise  = -1;
    startFall  = -1;
    startHigh  = 0;
    doneRise   = -1;
    firstReady = -1;
  endtask

  // One clock: sample outputs on the falling edge, then leave room to drive inputs.
  task automatic tick();
    @(negedge clock);
    cycleNo++;
    if (imemWe) begin
      wrAddr.push_back(int'(imemAddr));
      wrData.push_back(imemData);
      wrCyc.push_back(cycleNo);
    end
    if (startOut && !prevStart) startRise = cycleNo;
    if (!startOut && prevStart) startFall = cycleNo;
    if (startOut) startHigh++;
    if (doneOut && !prevDone) doneRise = cycleNo;
    if (readyOut && firstReady < 0) firstReady = cycleNo;
    prevStart = startOut;
    prevDone  = doneOut;
    #1;
  endtask

  task automatic markRelease();
    reset      = 1'b0;
    releaseCyc = cycleNo;
    firstReady = -1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    validIn  = 1'b0;
    stallIn  = 1'b0;
    branchIn = 1'b0;
    flushIn  = 1'b0;
    dataIn   = 8'h00;
    repeat (3) tick();
    checkOutput("rstFlags", 64'({readyOut, imemWe, startOut, doneOut, errOut}), 64'(0));
    checkOutput("rstAddrData", 64'({imemAddr, imemData}), 64'(0));
    checkOutput("rstCounters", 64'({runCycles, stallCnt, flushCnt}), 64'(0));
    clearLog();
    markRelease();
  endtask

  task automatic waitZeroFill();
    int badFill = 0;
    repeat (DEPTH + 1) tick();
    checkOutput("fillCount", 64'(wrAddr.size()), 64'(DEPTH));
    for (int i = 0; i < wrAddr.size(); i++) begin
      if (wrAddr[i] != i || wrData[i] != 32'h0 || wrCyc[i] != releaseCyc + 1 + i) badFill++;
    end
    checkOutput("fillPattern", 64'(badFill), 64'(0));
    checkOutput("firstReadyCycle", 64'(firstReady - releaseCyc), 64'(DEPTH + 1));
    checkOutput("readyAfterFill", 64'(readyOut), 64'(1));
    clearLog();
  endtask

  // Offer one byte after an optional idle gap and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int budget = 0;
    validIn = 1'b0;
    repeat (gap) tick();
    dataIn  = b;
    validIn = 1'b1;
    while (!readyOut && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) checkOutput("readyTimeout", 64'(readyOut), 64'(1));
    tick();
    validIn = 1'b0;
  endtask

  function automatic int pickGap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic sendStream(input int n, input int gapMode);
    logic [15:0] nn = 16'(n);
    applyStimulus(nn[7:0], pickGap(gapMode));
    applyStimulus(nn[15:8], pickGap(gapMode));
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(8'((prog[w] >> (8 * k)) & 32'hFF), pickGap(gapMode));
      end
    end
  endtask

  task automatic runAndCheck(input string name, input int n, input bit randomCnt, input int hdrCyc);
    int budget = 0;
    int expStall = 0;
    int expFlush = 0;
    int refCyc;
    bit s, b, f;
    while (!startOut && budget < 100) begin
      tick();
      budget++;
    end
    checkOutput({name, "-startSeen"}, 64'(startOut), 64'(1));
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      if (randomCnt) begin
        s = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        f = 1'($urandom_range(0, 1));
      end else begin
        s = (i < 5);
        b = (i == 1 || i == 3);
        f = (i >= 4 && i < 7);
      end
      stallIn  = s;
      branchIn = b;
      flushIn  = f;
      if (s && !b) expStall++;
      if (f) expFlush++;
      tick();
    end
    stallIn  = 1'b0;
    branchIn = 1'b0;
    flushIn  = 1'b0;
    budget = 0;
    while (!doneOut && budget < 200) begin
      tick();
      budget++;
    end
    repeat (2) tick();
    checkOutput({name, "-writeCount"}, 64'(wrAddr.size()), 64'(n));
    for (int i = 0; i < wrAddr.size() && i < n; i++) begin
      checkOutput($sformatf("%s-addr%0d", name, i), 64'(wrAddr[i]), 64'(i));
      checkOutput($sformatf("%s-data%0d", name, i), 64'(wrData[i]), 64'(prog[i]));
    end
    if (n == 0) refCyc = hdrCyc;
    else if (wrCyc.size() > 0) refCyc = wrCyc[wrCyc.size() - 1];
    else refCyc = -100;
    checkOutput({name, "-startDelay"}, 64'(startRise - refCyc), 64'(2));
    checkOutput({name, "-startWidth"}, 64'(startHigh), 64'(MAXC));
    checkOutput({name, "-doneAtFall"}, 64'(doneRise - startFall), 64'(0));
    checkOutput({name, "-runCycles"}, 64'(runCycles), 64'(MAXC));
    checkOutput({name, "-stallCnt"}, 64'(stallCnt), 64'(expStall));
    checkOutput({name, "-flushCnt"}, 64'(flushCnt), 64'(expFlush));
    checkOutput({name, "-finalFlags"}, 64'({doneOut, startOut, readyOut, errOut}), 64'(4'b1000));
  endtask

  initial begin
    int n;

    $display("[TB] reset and zero-fill");
    doReset();
    waitZeroFill();

    $display("[TB] two-word program, back-to-back bytes");
    prog = '{32'h00500113, 32'h00000033};
    sendStream(2, 0);
    runAndCheck("prog2", 2, 1'b0, 0);

    $display("[TB] same program, valid toggled every other cycle");
    doReset();
    waitZeroFill();
    sendStream(2, 1);
    runAndCheck("prog2gap", 2, 1'b1, 0);

    $display("[TB] random program with random gaps");
    doReset();
    waitZeroFill();
    prog.delete();
    n = int'($urandom_range(3, 8));
    for (int i = 0; i < n; i++) prog.push_back($urandom());
    sendStream(n, 2);
    runAndCheck("progRand", n, 1'b1, 0);

    $display("[TB] empty program");
    doReset();
    waitZeroFill();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    runAndCheck("progEmpty", 0, 1'b1, cycleNo);

    $display("[TB] oversized header");
    doReset();
    waitZeroFill();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    tick();
    checkOutput("errFlag", 64'(errOut), 64'(1));
    checkOutput("errReady", 64'(readyOut), 64'(0));
    validIn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dataIn = 8'($urandom());
      tick();
    end
    validIn = 1'b0;
    checkOutput("errNoStart", 64'(startHigh), 64'(0));
    checkOutput("errNoWrites", 64'(wrAddr.size()), 64'(0));
    checkOutput("errHeld", 64'({errOut, readyOut, doneOut}), 64'(3'b100));

    $display("[TB] reset mid-word");
    doReset();
    waitZeroFill();
    prog = '{32'hA5C3_1E77};
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hDE, 0);
    applyStimulus(8'hAD, 0);
    reset = 1'b1;
    tick();
    checkOutput("midRstNextCycle", 64'({readyOut, imemWe, startOut}), 64'(0));
    tick();
    markRelease();
    waitZeroFill();
    sendStream(1, 0);
    runAndCheck("afterMidRst", 1, 1'b0, 0);

    $display("[TB] full-depth program");
    doReset();
    waitZeroFill();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
    sendStream(DEPTH, 0);
    runAndCheck("progFull", DEPTH, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
